// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// -------------
// Program-counter and instruction-fetch front end. Holds the fetch PC,
// issues one instruction-memory request at a time, and buffers returned
// words with their fetch addresses in a 2-entry FIFO for the decode stage.
// A redirect (pc_load) flushes the FIFO and restarts fetch at incr_pc.
//
// Optional feature: define PC_FETCH_BYPASS_EN to present a returning word
// to decode combinationally when the FIFO is empty. A word consumed that
// way is not written into the FIFO.
//
// Ports
//   clk          in   1   clock, all state updates on posedge
//   reset        in   1   asynchronous, active-low reset
//   incr_pc      in  32   redirect target word address
//   pc_load      in   1   redirect strobe (highest priority)
//   pc           out 32   current fetch word address
//   imem_req     out  1   instruction-memory request
//   imem_addr    out 32   request address (always equal to pc)
//   imem_ack     in   1   memory response strobe, imem_rdata valid with it
//   imem_rdata   in  32   fetched instruction word
//   instr_valid  out  1   decode-side valid
//   instr_ready  in   1   decode-side ready
//   instr        out 32   instruction word at the FIFO head
//   instr_pc     out 32   fetch address of that instruction word
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] incr_pc,
  input  logic        pc_load,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  entry_t      mem_q [2];
  entry_t      head;

  logic fetch_ack;
  logic fifo_valid;
  logic bypass_hit;
  logic push;
  logic pop;

  // run_q keeps imem_req low while reset is held and raises it on the first
  // clock edge after release, independent of the FSM state.
  assign imem_req   = run_q && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;

  assign fetch_ack  = imem_req && imem_ack;
  assign fifo_valid = (count_q != 2'd0);
  assign head       = mem_q[rd_ptr_q];

`ifdef PC_FETCH_BYPASS_EN
  assign bypass_hit = !fifo_valid && fetch_ack && !pc_load;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word that decode accepts in the same cycle never enters the FIFO.
  assign push = fetch_ack && !pc_load && !(bypass_hit && instr_ready);
  assign pop  = fifo_valid && instr_ready && !pc_load;

  assign instr_valid = fifo_valid || bypass_hit;
  assign instr       = fifo_valid ? head.instr : (bypass_hit ? imem_rdata : 32'h0);
  assign instr_pc    = fifo_valid ? head.pc    : (bypass_hit ? pc_q       : 32'h0);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    if (pc_load) begin
      state_d = S_FETCH;
      pc_d    = incr_pc;
      count_d = 2'd0;
    end else begin
      // The PC advances on every accepted response, bypassed or buffered.
      if (fetch_ack) begin
        pc_d = pc_q + 32'd1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      // In FETCH the FIFO never holds more than one entry, so a push can
      // only fill it, never overflow it; HOLD stops requests until a pop.
      unique case (state_q)
        S_FETCH: if (push && !pop && (count_q == 2'd1)) state_d = S_HOLD;
        S_HOLD:  if (pop)                                state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (pc_load) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the outputs are gated by
  // the occupancy count, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: pc_q, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. Inputs change 1 time unit after a
// rising edge; outputs are sampled in the same quiet window.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] incr_pc;
  logic        pc_load;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .incr_pc     (incr_pc),
    .pc_load     (pc_load),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    incr_pc     = 32'h0;
    pc_load     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;

    // Reset values
    #3;
    check("rst_pc",       pc,          32'h0);
    check("rst_addr",     imem_addr,   32'h0);
    check("rst_req",      imem_req,    32'h0);
    check("rst_valid",    instr_valid, 32'h0);
    check("rst_instr",    instr,       32'h0);
    check("rst_instr_pc", instr_pc,    32'h0);
    tick();
    tick();
    check("rst_req_held", imem_req, 32'h0);

    // Request rises on the first edge after release
    reset = 1'b1;
    tick();
    check("rel_req",   imem_req,    32'h1);
    check("rel_pc",    pc,          32'h0);
    check("rel_valid", instr_valid, 32'h0);

    // Streaming: ack and ready every cycle, rdata = addr + 0x100
    imem_ack    = 1'b1;
    imem_rdata  = 32'h100;
    instr_ready = 1'b1;
    #1;
`ifdef PC_FETCH_BYPASS_EN
    check("byp_valid",    instr_valid, 32'h1);
    check("byp_instr",    instr,       32'h100);
    check("byp_instr_pc", instr_pc,    32'h0);
`else
    check("nobyp_valid",  instr_valid, 32'h0);
`endif
    for (int k = 1; k <= 3; k++) begin
      tick();
      imem_rdata = 32'h100 + k;
      #1;
`ifdef PC_FETCH_BYPASS_EN
      check("str_instr_pc", instr_pc, k);
      check("str_instr",    instr,    32'h100 + k);
`else
      check("str_instr_pc", instr_pc, k - 1);
      check("str_instr",    instr,    32'h100 + k - 1);
`endif
      check("str_valid", instr_valid, 32'h1);
      check("str_pc",    pc,          k);
      check("str_req",   imem_req,    32'h1);
    end
    imem_ack = 1'b0;
    tick();
    check("str_drain_valid", instr_valid, 32'h0);
    check("str_drain_pc",    pc,          32'h3);

    // Reset while a request is outstanding
    reset = 1'b0;
    #1;
    check("rstreq_req",   imem_req,    32'h0);
    check("rstreq_pc",    pc,          32'h0);
    check("rstreq_valid", instr_valid, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("bp_start_req", imem_req, 32'h1);

    // Back-pressure: ready low, two pushes then HOLD
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h100;
    tick();
    check("bp1_pc",       pc,          32'h1);
    check("bp1_req",      imem_req,    32'h1);
    check("bp1_instr_pc", instr_pc,    32'h0);
    imem_rdata = 32'h101;
    tick();
    check("bp2_req",      imem_req, 32'h0);
    check("bp2_pc",       pc,       32'h2);
    check("bp2_instr_pc", instr_pc, 32'h0);
    check("bp2_instr",    instr,    32'h100);
    tick();
    check("hold_ign_pc",  pc,       32'h2);
    check("hold_ign_req", imem_req, 32'h0);
    check("hold_ign_ipc", instr_pc, 32'h0);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("pop_instr_pc", instr_pc,    32'h1);
    check("pop_instr",    instr,       32'h101);
    check("pop_req",      imem_req,    32'h1);
    check("pop_valid",    instr_valid, 32'h1);
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h102;
    tick();
    check("refill_pc",  pc,       32'h3);
    check("refill_req", imem_req, 32'h0);

    // Reset with the FIFO full
    reset = 1'b0;
    #1;
    check("rstfull_valid",    instr_valid, 32'h0);
    check("rstfull_req",      imem_req,    32'h0);
    check("rstfull_pc",       pc,          32'h0);
    check("rstfull_instr",    instr,       32'h0);
    check("rstfull_instr_pc", instr_pc,    32'h0);
    imem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Redirect to 4, fill with pc 4,5, then flush to 0x40 with ack pending
    pc_load = 1'b1;
    incr_pc = 32'h4;
    tick();
    check("ld4_pc",    pc,          32'h4);
    check("ld4_valid", instr_valid, 32'h0);
    pc_load    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h104;
    tick();
    imem_rdata = 32'h105;
    tick();
    check("fill_pc",       pc,       32'h6);
    check("fill_instr_pc", instr_pc, 32'h4);
    pc_load     = 1'b1;
    incr_pc     = 32'h40;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    tick();
    check("flush_valid", instr_valid, 32'h0);
    check("flush_addr",  imem_addr,   32'h40);
    check("flush_req",   imem_req,    32'h1);
    pc_load     = 1'b0;
    imem_rdata  = 32'h140;
    instr_ready = 1'b0;
    tick();
    check("redir_instr_pc", instr_pc, 32'h40);
    check("redir_instr",    instr,    32'h140);
    check("redir_pc",       pc,       32'h41);

    // Flush in FETCH with ack: response data dropped, wrap at 0xFFFF_FFFF
    pc_load    = 1'b1;
    incr_pc    = 32'hFFFF_FFFF;
    imem_rdata = 32'h0000_0BAD;
    tick();
    check("ldmax_valid", instr_valid, 32'h0);
    check("ldmax_pc",    pc,          32'hFFFF_FFFF);
    pc_load    = 1'b0;
    imem_rdata = 32'h1234;
    tick();
    check("wrap_pc",       pc,       32'h0);
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFF);
    check("wrap_instr",    instr,    32'h1234);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("end_valid", instr_valid, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
